// File: rtl/countdown_timer_pkg.sv
// Shared encodings, field widths and the seconds clamp helper for the countdown timer.
package countdown_timer_pkg;

  localparam int MIN_W   = 8;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } status_e;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] sec);
    return (sec > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : sec;
  endfunction

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Divides clk down to a one-cycle tick every CLKS_PER_SEC enabled cycles; held at zero when disabled.
module tick_prescaler #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = enable && (cnt_reg == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (!enable || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with start/stop/clear/load control and expiry alarm.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic [1:0]       status,
  output logic             done,
  output logic             alarm
);

  status_e          state_reg, state_next;
  logic [MIN_W-1:0] min_reg, min_next;
  logic [SEC_W-1:0] sec_reg, sec_next;
  logic             done_reg, done_next;
  logic             alarm_reg;
  logic             tick;
  logic             presc_rst;
  logic             value_zero;

  assign value_zero = (min_reg == '0) && (sec_reg == '0);

  // The prescaler restarts whenever the timer is about to leave RUNNING, so it
  // already reads zero in the first cycle of any non-running state.
  assign presc_rst = rst || (state_next != ST_RUNNING);

  tick_prescaler #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .rst   (presc_rst),
    .enable(state_reg == ST_RUNNING),
    .tick  (tick)
  );

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    done_next  = 1'b0;

    if (clear) begin
      state_next = ST_IDLE;
      min_next   = '0;
      sec_next   = '0;
    end else if (load && (state_reg != ST_RUNNING)) begin
      state_next = ST_IDLE;
      min_next   = load_min;
      sec_next   = clamp_sec(load_sec);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!stop && start && !value_zero) begin
            state_next = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (tick) begin
            if (sec_reg != '0) begin
              sec_next = sec_reg - 1'b1;
            end else if (min_reg != '0) begin
              min_next = min_reg - 1'b1;
              sec_next = SEC_W'(SEC_MAX);
            end
            // Expiry wins over a coincident stop.
            if ((min_next == '0) && (sec_next == '0)) begin
              state_next = ST_EXPIRED;
              done_next  = 1'b1;
            end else if (stop) begin
              state_next = ST_PAUSED;
            end
          end else if (stop) begin
            state_next = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!stop && start) begin
            state_next = ST_RUNNING;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      min_reg   <= '0;
      sec_reg   <= '0;
      done_reg  <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      min_reg   <= min_next;
      sec_reg   <= sec_next;
      done_reg  <= done_next;
      alarm_reg <= (state_next == ST_EXPIRED);
    end
  end

  assign minutes = min_reg;
  assign seconds = sec_reg;
  assign status  = state_reg;
  assign done    = done_reg;
  assign alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer with a four-cycle second.
module tb_countdown_timer;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] PAUS = 2'b10;
  localparam logic [1:0] EXPD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic       done;
  logic       alarm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    bit         chk;
    logic [7:0] m;
    logic [5:0] s;
    logic [1:0] st;
    logic       d;
    logic       a;
  } exp_t;

  exp_t sb[$];

  countdown_timer #(.CLKS_PER_SEC(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic step(input string tag, input bit chk, input logic [7:0] em, input logic [5:0] es,
                      input logic [1:0] est, input logic ed, input logic ea);
    exp_t e;
    e.tag = tag; e.chk = chk; e.m = em; e.s = es; e.st = est; e.d = ed; e.a = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    e = sb.pop_front();
    if (e.chk) begin
      checks++;
      assert ({minutes, seconds} === {e.m, e.s}) else begin
        errors++;
        $error("FAIL %s value got %0d:%0d exp %0d:%0d", e.tag, minutes, seconds, e.m, e.s);
      end
      checks++;
      assert (status === e.st) else begin
        errors++;
        $error("FAIL %s status got %b exp %b", e.tag, status, e.st);
      end
      checks++;
      assert ({done, alarm} === {e.d, e.a}) else begin
        errors++;
        $error("FAIL %s done/alarm got %b%b exp %b%b", e.tag, done, alarm, e.d, e.a);
      end
      $display("step %-14s mm:ss=%0d:%0d status=%b done=%b alarm=%b", e.tag, minutes, seconds,
               status, done, alarm);
    end
  endtask

  task automatic set_load(input logic [7:0] m, input logic [5:0] s);
    load = 1'b1; load_min = m; load_sec = s;
  endtask

  initial begin
    #1;
    // Reset overrides simultaneous start and load.
    rst = 1'b1; start = 1'b1; set_load(8'd5, 6'd5);
    step("reset", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_zero_rst", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);

    // Basic countdown 00:02.
    set_load(8'd0, 6'd2);
    step("load_0002", 1, 8'd0, 6'd2, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0002", 1, 8'd0, 6'd2, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_0002", 1, 8'd0, 6'd2, RUN, 1'b0, 1'b0);
    step("tick_0001", 1, 8'd0, 6'd1, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_0001", 1, 8'd0, 6'd1, RUN, 1'b0, 1'b0);
    step("expire", 1, 8'd0, 6'd0, EXPD, 1'b1, 1'b1);
    step("done_once", 1, 8'd0, 6'd0, EXPD, 1'b0, 1'b1);
    start = 1'b1;
    step("start_in_exp", 1, 8'd0, 6'd0, EXPD, 1'b0, 1'b1);
    stop = 1'b1;
    step("stop_in_exp", 1, 8'd0, 6'd0, EXPD, 1'b0, 1'b1);

    // Borrow from minutes.
    set_load(8'd1, 6'd0);
    step("load_0100", 1, 8'd1, 6'd0, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0100", 1, 8'd1, 6'd0, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_0100", 1, 8'd1, 6'd0, RUN, 1'b0, 1'b0);
    step("borrow_0059", 1, 8'd0, 6'd59, RUN, 1'b0, 1'b0);
    set_load(8'd9, 6'd9);
    step("load_in_run", 1, 8'd0, 6'd59, RUN, 1'b0, 1'b0);

    // Pause for 21 cycles of stop, then resume.
    stop = 1'b1;
    step("pause", 1, 8'd0, 6'd59, PAUS, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      stop = 1'b1;
      step("paused_hold", 1, 8'd0, 6'd59, PAUS, 1'b0, 1'b0);
    end
    start = 1'b1;
    step("resume", 1, 8'd0, 6'd59, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("resume_hold", 1, 8'd0, 6'd59, RUN, 1'b0, 1'b0);
    step("resume_tick", 1, 8'd0, 6'd58, RUN, 1'b0, 1'b0);

    // Stop coinciding with the final tick.
    stop = 1'b1;
    step("pause2", 1, 8'd0, 6'd58, PAUS, 1'b0, 1'b0);
    set_load(8'd0, 6'd1);
    step("load_0001", 1, 8'd0, 6'd1, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0001", 1, 8'd0, 6'd1, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_last", 1, 8'd0, 6'd1, RUN, 1'b0, 1'b0);
    stop = 1'b1;
    step("stop_tick_exp", 1, 8'd0, 6'd0, EXPD, 1'b1, 1'b1);
    clear = 1'b1;
    step("clear_exp", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);

    // Seconds clamp and zero start.
    set_load(8'd3, 6'd61);
    step("clamp_0359", 1, 8'd3, 6'd59, IDLE, 1'b0, 1'b0);
    set_load(8'd0, 6'd0);
    step("load_0000", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_zero", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);

    // Clear beats load while running.
    set_load(8'd2, 6'd0);
    step("load_0200", 1, 8'd2, 6'd0, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0200", 1, 8'd2, 6'd0, RUN, 1'b0, 1'b0);
    step("run_0200", 1, 8'd2, 6'd0, RUN, 1'b0, 1'b0);
    clear = 1'b1; set_load(8'd7, 6'd7);
    step("clear_load", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);

    // Reset mid-countdown discards the time.
    set_load(8'd5, 6'd30);
    step("load_0530", 1, 8'd5, 6'd30, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0530", 1, 8'd5, 6'd30, RUN, 1'b0, 1'b0);
    step("run_0530", 0, 8'd5, 6'd30, RUN, 1'b0, 1'b0);
    rst = 1'b1;
    step("rst_run", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);
    start = 1'b1;
    step("start_post_rst", 1, 8'd0, 6'd0, IDLE, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
